// File: rtl/lifo_multi.sv
// Bank of CH independent LIFO stacks sharing one push/pop port selected by ch_i.
// Reads are combinational from the top of the selected stack; overflow/underflow flags are sticky.
module lifo_multi #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int CH    = 2,
  localparam int AW   = $clog2(DEPTH + 1),
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_a_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [CW-1:0] ch_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] level_o,
  output logic [CH-1:0] empty_o,
  output logic [CH-1:0] full_o,
  output logic [CH-1:0] ovf_o,
  output logic [CH-1:0] unf_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [CH][DEPTH];
  logic [AW-1:0] ptr_q [CH];
  logic [IW-1:0] top_idx [CH];
  logic [CH-1:0] sel;

  // A ch_i value with no matching channel leaves sel all-zero, so nothing moves.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sel[c]     = (ch_i == CW'(c));
      empty_o[c] = (ptr_q[c] == '0);
      full_o[c]  = (ptr_q[c] == AW'(DEPTH));
      top_idx[c] = IW'(ptr_q[c] - AW'(1));
    end
  end

  always_comb begin
    data_o  = '0;
    level_o = '0;
    for (int c = 0; c < CH; c++) begin
      if (sel[c]) begin
        level_o = ptr_q[c];
        if (!empty_o[c]) data_o = mem[c][top_idx[c]];
      end
    end
  end

  // Push+pop on a non-empty stack replaces the top; on an empty stack it is a plain push.
  always_ff @(posedge clk_a_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CH; c++) ptr_q[c] <= '0;
      ovf_o <= '0;
      unf_o <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < CH; c++) ptr_q[c] <= '0;
      ovf_o <= '0;
      unf_o <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (sel[c]) begin
          if (push_i && pop_i && !empty_o[c]) begin
            ptr_q[c] <= ptr_q[c];
          end else if (push_i) begin
            if (full_o[c]) ovf_o[c] <= 1'b1;
            else           ptr_q[c] <= ptr_q[c] + AW'(1);
          end else if (pop_i) begin
            if (empty_o[c]) unf_o[c] <= 1'b1;
            else            ptr_q[c] <= ptr_q[c] - AW'(1);
          end
        end
      end
    end
  end

  // Storage is never reset: entries above the pointer are unreachable.
  always_ff @(posedge clk_a_i) begin
    if (!clear_i && push_i) begin
      for (int c = 0; c < CH; c++) begin
        if (sel[c]) begin
          if (pop_i && !empty_o[c]) mem[c][top_idx[c]] <= data_i;
          else if (!full_o[c])      mem[c][IW'(ptr_q[c])] <= data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_lifo_multi.sv
// Directed and randomized checks of lifo_multi (DW=16, DEPTH=4, CH=2) against queue-based stacks.
module tb_lifo_multi;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int CH = 2;

  logic          clk_a_i = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          clear_i = 1'b0;
  logic [0:0]    ch_i    = '0;
  logic          push_i  = 1'b0;
  logic          pop_i   = 1'b0;
  logic [DW-1:0] data_i  = '0;
  logic [DW-1:0] data_o;
  logic [2:0]    level_o;
  logic [CH-1:0] empty_o, full_o, ovf_o, unf_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue per channel, back of queue is the top of stack.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [CH-1:0] m_ovf = '0;
  logic [CH-1:0] m_unf = '0;

  lifo_multi #(.DW(DW), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk_a_i(clk_a_i), .rst_ni(rst_ni), .clear_i(clear_i), .ch_i(ch_i),
    .push_i(push_i), .pop_i(pop_i), .data_i(data_i), .data_o(data_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_a_i = ~clk_a_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input int c);
    return (c == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [DW-1:0] m_top(input int c);
    if (m_size(c) == 0) return '0;
    return (c == 0) ? exp_q0[exp_q0.size()-1] : exp_q1[exp_q1.size()-1];
  endfunction

  task automatic m_clear();
    exp_q0.delete();
    exp_q1.delete();
    m_ovf = '0;
    m_unf = '0;
  endtask

  task automatic m_apply(input int c, input logic pu, input logic po, input logic [DW-1:0] d, input logic cl);
    int lvl;
    if (cl) begin
      m_clear();
      return;
    end
    lvl = m_size(c);
    if (pu && po && lvl > 0) begin
      if (c == 0) exp_q0[lvl-1] = d; else exp_q1[lvl-1] = d;
    end else if (pu) begin
      if (lvl == DEPTH) m_ovf[c] = 1'b1;
      else if (c == 0) exp_q0.push_back(d);
      else exp_q1.push_back(d);
    end else if (po) begin
      if (lvl == 0) m_unf[c] = 1'b1;
      else if (c == 0) void'(exp_q0.pop_back());
      else void'(exp_q1.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    logic [CH-1:0] e_empty, e_full;
    for (int c = 0; c < CH; c++) begin
      e_empty[c] = (m_size(c) == 0);
      e_full[c]  = (m_size(c) == DEPTH);
    end
    chk({tag, ".data"},  32'(data_o),  32'(m_top(int'(ch_i))));
    chk({tag, ".level"}, 32'(level_o), 32'(m_size(int'(ch_i))));
    chk({tag, ".empty"}, 32'(empty_o), 32'(e_empty));
    chk({tag, ".full"},  32'(full_o),  32'(e_full));
    chk({tag, ".ovf"},   32'(ovf_o),   32'(m_ovf));
    chk({tag, ".unf"},   32'(unf_o),   32'(m_unf));
  endtask

  // Drive one operation just after a falling edge, check before and after the rising edge.
  task automatic cyc(input string tag, input int c, input logic pu, input logic po,
                     input logic [DW-1:0] d, input logic cl);
    ch_i = c[0:0]; push_i = pu; pop_i = po; data_i = d; clear_i = cl;
    #1 check_all({tag, ".pre"});
    @(posedge clk_a_i);
    m_apply(c, pu, po, d, cl);
    @(negedge clk_a_i);
    push_i = 1'b0; pop_i = 1'b0; clear_i = 1'b0;
    #1 check_all({tag, ".post"});
  endtask

  task automatic look(input int c);
    ch_i = c[0:0];
    #1;
  endtask

  initial begin
    // Reset state
    #2 check_all("rst");
    @(negedge clk_a_i);
    rst_ni = 1'b1;
    #1 check_all("rst_rel");

    // LIFO order on ch0
    cyc("p11", 0, 1, 0, 16'h0011, 0);
    cyc("p22", 0, 1, 0, 16'h0022, 0);
    cyc("p33", 0, 1, 0, 16'h0033, 0);
    chk("ch0_lvl3", 32'(level_o), 32'd3);
    chk("ch0_top33", 32'(data_o), 32'h33);
    ch_i = 1'b0; pop_i = 1'b1; #1 chk("pop_sees33", 32'(data_o), 32'h33);
    @(posedge clk_a_i); m_apply(0, 0, 1, '0, 0); @(negedge clk_a_i); pop_i = 1'b0;
    #1 chk("pop_sees22", 32'(data_o), 32'h22);
    cyc("pop2", 0, 0, 1, '0, 0);
    chk("pop_sees11", 32'(data_o), 32'h11);
    cyc("pop3", 0, 0, 1, '0, 0);
    chk("ch0_empty", 32'(empty_o[0]), 32'd1);

    // Overflow on ch1
    for (int i = 1; i <= 5; i++) begin
      cyc("p_ch1", 1, 1, 0, 16'(16'h00A0 + i), 0);
      if (i == 4) chk("ch1_full", 32'(full_o[1]), 32'd1);
    end
    chk("ch1_ovf", 32'(ovf_o[1]), 32'd1);
    chk("ch1_lvl4", 32'(level_o), 32'd4);
    chk("ch1_top4th", 32'(data_o), 32'h00A4);

    // Underflow on ch0 leaves ch1 untouched
    cyc("unf0", 0, 0, 1, '0, 0);
    chk("ch0_unf", 32'(unf_o[0]), 32'd1);
    chk("ch0_lvl0", 32'(level_o), 32'd0);
    look(1);
    chk("ch1_keep_lvl", 32'(level_o), 32'd4);
    chk("ch1_keep_top", 32'(data_o), 32'h00A4);

    // Simultaneous push/pop replaces the top
    cyc("pAA", 0, 1, 0, 16'h00AA, 0);
    cyc("pBB", 0, 1, 0, 16'h00BB, 0);
    cyc("rplCC", 0, 1, 1, 16'h00CC, 0);
    chk("rpl_lvl", 32'(level_o), 32'd2);
    chk("rpl_top", 32'(data_o), 32'h00CC);
    cyc("pDD", 0, 1, 0, 16'h00DD, 0);
    cyc("pEE", 0, 1, 0, 16'h00EE, 0);
    cyc("rplFF", 0, 1, 1, 16'h00FF, 0);
    chk("rpl_full_noovf", 32'(ovf_o[0]), 32'd0);
    chk("rpl_full_top", 32'(data_o), 32'h00FF);
    // Push+pop on an empty channel after a clear acts as a push
    cyc("clr_push", 1, 1, 0, 16'h1234, 1);
    chk("clr_lvl", 32'(level_o), 32'd0);
    chk("clr_flags", 32'({ovf_o, unf_o}), 32'd0);
    cyc("pp_empty", 1, 1, 1, 16'h5A5A, 0);
    chk("pp_empty_unf", 32'(unf_o[1]), 32'd0);
    cyc("pop_e", 1, 0, 1, '0, 0);

    // Asynchronous reset between edges with ch1 at level 3
    for (int i = 0; i < 3; i++) cyc("p_pre_rst", 1, 1, 0, 16'($urandom), 0);
    chk("pre_rst_lvl", 32'(level_o), 32'd3);
    #2 rst_ni = 1'b0;
    #1 m_clear();
    chk("arst_empty", 32'(empty_o), 32'b11);
    chk("arst_lvl", 32'(level_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    @(negedge clk_a_i);
    rst_ni = 1'b1;
    cyc("pop_after_rst", 1, 0, 1, '0, 0);
    chk("rst_unf1", 32'(unf_o[1]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc("rnd", int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lifo_multi.md
LIFO_MULTI -- requirements
Module: lifo_multi

Interface
REQ-001 SHALL have parameter DW, default 16: data width in bits, range 1..64.
REQ-002 SHALL have parameter DEPTH, default 16: entries per channel, range 2..1024, any integer.
REQ-003 SHALL have parameter CH, default 2: number of independent stacks, range 1..8.
REQ-004 SHALL derive AW = clog2(DEPTH+1) as the level width, and CW = max(1, clog2(CH)) as the channel-select width.
REQ-005 SHALL have port clk_a_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous flush of all channels and error flags.
REQ-008 SHALL have port ch_i, input, CW bits: selects the channel for push, pop, data_o and level_o.
REQ-009 SHALL have port push_i, input, 1 bit: push data_i onto the selected channel.
REQ-010 SHALL have port pop_i, input, 1 bit: pop the top of the selected channel.
REQ-011 SHALL have port data_i, input, DW bits: push data.
REQ-012 SHALL have port data_o, output, DW bits: top entry of the selected channel.
REQ-013 SHALL have port level_o, output, AW bits: entry count of the selected channel.
REQ-014 SHALL have port empty_o, output, CH bits: per-channel empty flag (level == 0).
REQ-015 SHALL have port full_o, output, CH bits: per-channel full flag (level == DEPTH).
REQ-016 SHALL have port ovf_o, output, CH bits: per-channel sticky overflow flag.
REQ-017 SHALL have port unf_o, output, CH bits: per-channel sticky underflow flag.

Function
REQ-018 SHALL keep one pointer per channel, range 0..DEPTH; the pointer is the level and the next free slot.
REQ-019 SHALL drive data_o combinationally with stack[ch_i][ptr-1] (zero read latency), and with 0 when the selected channel is empty.
REQ-020 SHALL drive level_o, empty_o and full_o combinationally from the pointer registers.
REQ-021 SHALL, on push only with the channel not full: write data_i at ptr and increment ptr.
REQ-022 SHALL, on pop only with the channel not empty: decrement ptr; the popped value is the data_o shown in the same cycle.
REQ-023 SHALL, on push and pop together with the channel not empty (including full): overwrite the top entry with data_i, leave ptr unchanged and set no flag.
REQ-024 SHALL, on push and pop together with the channel empty: perform a push only and set no underflow.
REQ-025 SHALL, on push only with the channel full: drop the write, leave ptr unchanged and set ovf_o[ch_i].
REQ-026 SHALL, on pop only with the channel empty: leave ptr unchanged and set unf_o[ch_i].
REQ-027 SHALL leave unselected channels unaffected in every cycle.
REQ-028 SHALL, on clear_i, set all pointers, ovf_o and unf_o to 0 on the next edge; clear_i has priority over push_i and pop_i in the same cycle.
REQ-029 SHALL treat a ch_i value >= CH as selecting no channel: push and pop are ignored, no flag is set, and data_o and level_o read 0.
REQ-030 SHALL hold ovf_o and unf_o at 1 once set, until clear_i or reset.

Reset
REQ-031 SHALL, while rst_ni = 0, force all pointers, ovf_o and unf_o to 0 immediately, so that empty_o = all ones, full_o = 0, level_o = 0 and data_o = 0.
REQ-032 SHALL not reset the storage array; its contents are don't-care after reset because they are unreachable.
REQ-033 SHALL, on reset asserted mid-operation, discard all stacked data; the first cycle after release behaves as empty.

Verification (DW=16, DEPTH=4, CH=2)
REQ-034 Bench SHALL push 0x11, 0x22, 0x33 on ch0 -> level_o=3 and data_o=0x33; then pop three times -> data_o shows 0x33, 0x22, 0x11 in turn, then empty_o[0]=1.
REQ-035 Bench SHALL push 5 values on ch1 -> after the 4th push full_o[1]=1; the 5th push sets ovf_o[1]=1, leaves level_o=4, and leaves the top entry as the 4th value.
REQ-036 Bench SHALL pop ch0 while empty -> unf_o[0]=1, level_o=0, and ch1 is unchanged.
REQ-037 Bench SHALL, with ch0 holding 0xAA, 0xBB, assert push 0xCC and pop together -> level_o=2 and data_o=0xCC; the same with ch0 full -> no ovf_o.
REQ-038 Bench SHALL, with both channels non-empty and flags set, assert clear_i together with push -> all levels 0, ovf_o=unf_o=0, and the push is ignored.
REQ-039 Bench SHALL assert rst_ni low asynchronously between edges while ch1 is at level 3 -> empty_o=2'b11 is seen immediately, and after release the first pop sets unf_o[1].
